// File: rtl/of_ex_stage_reg.sv
// of_ex_stage_reg: operand-fetch -> execute pipeline register.
// Carries instruction, PC, branch target, both operands, immediate and control
// word with a valid/ready handshake, flush with bubble insertion and a
// saturating stall counter.
// Build option: define OFEX_SKID_EN for a 2-entry skid buffer with a registered
// in_ready (states EMPTY/ONE/TWO). The default build is a single register whose
// in_ready is !out_valid | out_ready.
module of_ex_stage_reg #(
  parameter int              XLEN      = 32,
  parameter int              CTRL_W    = 14,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h6800_0000,
  parameter int              CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instruction,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_branchtarget,
  input  logic [XLEN-1:0]   in_op1,
  input  logic [XLEN-1:0]   in_op2,
  input  logic [XLEN-1:0]   in_immx,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_instruction,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_branchtarget,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [XLEN-1:0]   out_immx,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Whole beat packed as {instr, pc, btarget, op1, op2, immx, ctrl}.
  localparam int BEAT_W = 6 * XLEN + CTRL_W;

  logic [BEAT_W-1:0] w_in_beat;
  logic [BEAT_W-1:0] r_main_data;
  logic              r_main_valid;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_emit;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_in_beat = {in_instruction, in_pc, in_branchtarget,
                      in_op1, in_op2, in_immx, in_ctrl};
  assign w_accept  = in_valid & w_in_ready;
  assign w_emit    = r_main_valid & out_ready;

`ifdef OFEX_SKID_EN

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic [BEAT_W-1:0] r_skid_data;

  assign w_in_ready = r_in_ready;

  // Skid FSM: main/skid occupancy, registered in_ready (= skid empty) and payload moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_EMPTY;
      r_main_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_main_data  <= {BEAT_W{1'b0}};
      r_skid_data  <= {BEAT_W{1'b0}};
    end else if (flush) begin
      // Redirect: drop everything held and anything offered this cycle.
      r_state      <= S_EMPTY;
      r_main_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state      <= S_ONE;
            r_main_valid <= 1'b1;
            r_main_data  <= w_in_beat;
          end
        end
        S_ONE: begin
          if (w_accept && !w_emit) begin
            // EX stalled: park the new beat behind the one in main.
            r_state     <= S_TWO;
            r_in_ready  <= 1'b0;
            r_skid_data <= w_in_beat;
          end else if (w_accept && w_emit) begin
            r_main_data <= w_in_beat;
          end else if (w_emit) begin
            r_state      <= S_EMPTY;
            r_main_valid <= 1'b0;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only the drain of main can happen.
          if (w_emit) begin
            r_state     <= S_ONE;
            r_in_ready  <= 1'b1;
            r_main_data <= r_skid_data;
          end
        end
        default: begin
          r_state      <= S_EMPTY;
          r_main_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end
      endcase
    end
  end

`else

  // Without a skid slot the stage can take a beat only if main is free or draining.
  assign w_in_ready = ~r_main_valid | out_ready;

  // Single register: load on accept, clear on emit without refill, clear on flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_data  <= {BEAT_W{1'b0}};
    end else if (flush) begin
      r_main_valid <= 1'b0;
    end else if (w_accept) begin
      r_main_valid <= 1'b1;
      r_main_data  <= w_in_beat;
    end else if (w_emit) begin
      r_main_valid <= 1'b0;
    end
  end

`endif

  // Performance counter: count back-pressured offers, saturate at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (in_valid && !w_in_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready         = w_in_ready;
  assign out_valid        = r_main_valid;
  assign stall_cnt        = r_stall_cnt;

  // Bubble gating uses only the registered valid bit.
  assign out_instruction  = r_main_valid ? r_main_data[CTRL_W+6*XLEN-1 -: XLEN] : NOP_INSTR;
  assign out_pc           = r_main_data[CTRL_W+5*XLEN-1 -: XLEN];
  assign out_branchtarget = r_main_data[CTRL_W+4*XLEN-1 -: XLEN];
  assign out_op1          = r_main_data[CTRL_W+3*XLEN-1 -: XLEN];
  assign out_op2          = r_main_data[CTRL_W+2*XLEN-1 -: XLEN];
  assign out_immx         = r_main_data[CTRL_W+XLEN-1 -: XLEN];
  assign out_ctrl         = r_main_valid ? r_main_data[CTRL_W-1:0] : {CTRL_W{1'b0}};

endmodule

// File: tb/tb_of_ex_stage_reg.sv
// Self-checking bench for of_ex_stage_reg (either build, follows OFEX_SKID_EN).
module tb_of_ex_stage_reg;

  localparam int          XLEN   = 32;
  localparam int          CTRL_W = 14;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] NOP    = 32'h6800_0000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [XLEN-1:0]   in_instruction = '0, in_pc = '0, in_branchtarget = '0;
  logic [XLEN-1:0]   in_op1 = '0, in_op2 = '0, in_immx = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   out_instruction, out_pc, out_branchtarget, out_op1, out_op2, out_immx;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  typedef struct {
    logic [31:0] ins, pc, bt, op1, op2, imm;
    logic [13:0] ctrl;
  } beat_t;

  beat_t            q[$];
  int               checks = 0;
  int               errors = 0;
  int               n_emit = 0;
  logic [CNT_W-1:0] m_stall = '0;
  bit               mon_en = 1'b0;

  of_ex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc), .in_branchtarget(in_branchtarget),
    .in_op1(in_op1), .in_op2(in_op2), .in_immx(in_immx), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc), .out_branchtarget(out_branchtarget),
    .out_op1(out_op1), .out_op2(out_op2), .out_immx(out_immx), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model of in_ready from the model occupancy.
  function automatic bit exp_ready();
`ifdef OFEX_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || (out_ready == 1'b1);
`endif
  endfunction

  task automatic drive(input bit v, input logic [31:0] pc, input bit ordy,
                       input bit fl, input logic [13:0] ctrl);
    in_valid        = v;
    in_pc           = pc;
    in_instruction  = {pc[15:0], 16'hA5C3};
    in_branchtarget = pc + 32'h0000_0100;
    in_op1          = ~pc;
    in_op2          = pc ^ 32'h5A5A_5A5A;
    in_immx         = {16'h0000, pc[15:0]} + 32'd7;
    in_ctrl         = ctrl;
    out_ready       = ordy;
    flush           = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare outputs against the model, then apply the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      bit    er, em, ac;
      beat_t b;
      er = exp_ready();
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL mon_out_valid got %0b expected %0b at %0t", out_valid, q.size() != 0, $time);
      end
      checks++;
      if (in_ready !== er) begin
        errors++;
        $display("FAIL mon_in_ready got %0b expected %0b at %0t", in_ready, er, $time);
      end
      checks++;
      if (stall_cnt !== m_stall) begin
        errors++;
        $display("FAIL mon_stall_cnt got %0h expected %0h at %0t", stall_cnt, m_stall, $time);
      end
      checks++;
      if (q.size() != 0) begin
        if ({out_instruction, out_pc, out_branchtarget, out_op1, out_op2, out_immx, out_ctrl} !==
            {q[0].ins, q[0].pc, q[0].bt, q[0].op1, q[0].op2, q[0].imm, q[0].ctrl}) begin
          errors++;
          $display("FAIL mon_beat got pc %h ins %h ctrl %h expected pc %h ins %h ctrl %h at %0t",
                   out_pc, out_instruction, out_ctrl, q[0].pc, q[0].ins, q[0].ctrl, $time);
        end
      end else if (out_instruction !== NOP || out_ctrl !== 14'h0) begin
        errors++;
        $display("FAIL mon_bubble got ins %h ctrl %h expected ins %h ctrl 0 at %0t",
                 out_instruction, out_ctrl, NOP, $time);
      end
      em = (q.size() != 0) && (out_ready == 1'b1);
      ac = (in_valid == 1'b1) && er;
      if (in_valid && !er && (m_stall != {CNT_W{1'b1}})) m_stall = m_stall + 4'd1;
      if (em) begin
        void'(q.pop_front());
        n_emit++;
      end
      if (flush) begin
        q.delete();
      end else if (ac) begin
        b.ins = in_instruction; b.pc = in_pc; b.bt = in_branchtarget;
        b.op1 = in_op1; b.op2 = in_op2; b.imm = in_immx; b.ctrl = in_ctrl;
        q.push_back(b);
      end
    end
  end

  task automatic test_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 14'h0);
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake got valid %0b ready %0b expected 0 1", out_valid, in_ready);
    end
    checks++;
    if ({out_pc, out_branchtarget, out_op1, out_op2, out_immx} !== 160'h0 ||
        out_instruction !== NOP || out_ctrl !== 14'h0 || stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL reset_payload got ins %h pc %h ctrl %h cnt %h expected %h 0 0 0",
               out_instruction, out_pc, out_ctrl, stall_cnt, NOP);
    end
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b1, 1'b0, 14'(i + 1));
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin
        errors++;
        $display("FAIL b2b_pc got valid %0b pc %h expected 1 %h", out_valid, out_pc, 32'(4 * i));
      end
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 14'h0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL b2b_end got valid %0b cnt %h expected 0 0", out_valid, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [CNT_W-1:0] base;
    base = m_stall;
    drive(1'b1, 32'h10, 1'b0, 1'b0, 14'h0011);
    tick();
    drive(1'b1, 32'h14, 1'b0, 1'b0, 14'h0022);
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_pc !== 32'h10) begin
      errors++;
      $display("FAIL bp_hold got ready %0b pc %h expected 0 00000010", in_ready, out_pc);
    end
    drive(1'b1, 32'h14, 1'b1, 1'b0, 14'h0022);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h14) begin
      errors++;
      $display("FAIL bp_second got valid %0b pc %h expected 1 00000014", out_valid, out_pc);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 14'h0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== base + 4'd2) begin
      errors++;
      $display("FAIL bp_drain got valid %0b ready %0b cnt %h expected 0 1 %h",
               out_valid, in_ready, stall_cnt, base + 4'd2);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h20, 1'b0, 1'b0, 14'h0101);
    tick();
    drive(1'b1, 32'h24, 1'b0, 1'b0, 14'h0202);
    tick();
    drive(1'b1, 32'h28, 1'b0, 1'b1, 14'h3FFF);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_instruction !== NOP || out_ctrl !== 14'h0) begin
      errors++;
      $display("FAIL flush_full got valid %0b ins %h ctrl %h expected 0 %h 0",
               out_valid, out_instruction, out_ctrl, NOP);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 14'h0);
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_leak got valid %0b pc %h expected 0", out_valid, out_pc);
    end
    drive(1'b1, 32'h2C, 1'b1, 1'b1, 14'h3FFF);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty_accept got valid %0b expected 0", out_valid);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 14'h0);
    tick();
  endtask

  task automatic test_toggle();
    logic [31:0] npc;
    int          e0;
    bit          er;
    npc = 32'h40;
    e0  = n_emit;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, npc, (c % 2) == 0, 1'b0, 14'(c + 5));
      #1;
      er = exp_ready();
      checks++;
      if (in_ready !== er) begin
        errors++;
        $display("FAIL toggle_ready got %0b expected %0b cycle %0d", in_ready, er, c);
      end
      tick();
      if (er) npc = npc + 32'd4;
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 14'h0);
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || (n_emit - e0) != int'((npc - 32'h40) / 4)) begin
      errors++;
      $display("FAIL toggle_count got valid %0b emitted %0d expected 0 %0d",
               out_valid, n_emit - e0, (npc - 32'h40) / 4);
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 32'h90, 1'b0, 1'b0, 14'h0333);
    for (int c = 0; c < 20; c++) tick();
    checks++;
    if (stall_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat_cnt got %h expected f", stall_cnt);
    end
    drive(1'b1, 32'h90, 1'b0, 1'b1, 14'h0333);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 14'h0);
    tick();
    checks++;
    if (stall_cnt !== 4'hF || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_after_flush got cnt %h valid %0b expected f 0", stall_cnt, out_valid);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h80, 1'b0, 1'b0, 14'h0444);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 14'h0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got valid %0b expected 1", out_valid);
    end
    mon_en = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL areset_now got valid %0b ready %0b cnt %h expected 0 1 0",
               out_valid, in_ready, stall_cnt);
    end
    q.delete();
    m_stall = '0;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({out_pc, out_branchtarget, out_op1, out_op2, out_immx} !== 160'h0 ||
        out_instruction !== NOP || out_ctrl !== 14'h0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_after got ins %h pc %h op1 %h ctrl %h ready %0b expected %h 0 0 0 1",
               out_instruction, out_pc, out_op1, out_ctrl, in_ready, NOP);
    end
    mon_en = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_toggle();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
